multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS core. Sequences fetch/decode/execute/memory/writeback per instruction.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mc_output_decode.sv | 98 +++++++++
 rtl/multicycle_control.sv | 93 +++++++++
 tb/tb_multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control FSM: opcodes, state encodings,
// datapath select codes and the decode-stage dispatch helper.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Encodings 13 and 14 are unused and fall into StError.
  typedef enum logic [3:0] {
    StReset   = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBranch  = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StJump    = 4'd12,
    StError   = 4'd15
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Decode-stage dispatch; opcodes disabled by configuration trap like unknown ones.
  function automatic state_e dispatch(input logic [5:0] op, input bit bne_en, input bit j_en);
    state_e st;
    case (op)
      OP_LW, OP_SW: st = StMemAdr;
      OP_RTYPE:     st = StRtypeEx;
      OP_BEQ:       st = StBranch;
      OP_BNE:       st = bne_en ? StBranch : StError;
      OP_ADDI:      st = StAddiEx;
      OP_J:         st = j_en ? StJump : StError;
      default:      st = StError;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word table for the multicycle control FSM.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic       is_bne_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       illegal_o
);

  logic pc_write;
  logic branch;

  // Moore decode; only the fetch-stage enables look at mem_ready.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    alu_op_o     = ALU_OP_ADD;
    pc_src_o     = PC_SRC_ALU;
    illegal_o    = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    case (state_i)
      StFetch: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      StDecode:  alu_src_b_o = SRC_B_IMM_SH2;
      StMemAdr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
      end
      StRtypeWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        branch      = 1'b1;
      end
      StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
      end
      StAddiWb:  reg_write_o = 1'b1;
      StJump: begin
        pc_src_o = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      StError:   illegal_o = 1'b1;
      default: ;
    endcase
    // bne inverts the sense of the zero flag.
    pc_en_o = pc_write | (branch & (zero_i ^ is_bne_i));
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: state register, next-state logic
// and the decode-stage instruction-class flags.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter bit SUPPORT_J   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   is_bne_q;
  logic   is_store_q;

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:   state_d = StFetch;
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode:  state_d = dispatch(opcode, SUPPORT_BNE, SUPPORT_J);
      StMemAdr:  state_d = is_store_q ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBranch:  state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StError:   state_d = StError;
      default:   state_d = StError;
    endcase
  end

  // State register plus instruction-class flags captured while in decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReset;
      is_bne_q   <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        is_bne_q   <= (opcode == OP_BNE);
        is_store_q <= (opcode == OP_SW);
      end
    end
  end

  assign state_dbg = state_q;

  mc_output_decode u_decode (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .is_bne_i     (is_bne_q),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .ir_write_o   (ir_write),
    .pc_en_o      (pc_en),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .illegal_o    (illegal)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-stream bench: the driver plans each instruction's cycle-by-cycle
// control word from the instruction-class rules and queues it; a negedge monitor compares.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] cur_op = 6'h00;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_req, mem_we, iord, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic illegal;
  logic [3:0] state_dbg;

  logic m2_mem_req, m2_mem_we, m2_iord, m2_ir_write, m2_pc_en, m2_reg_dst, m2_mem_to_reg;
  logic m2_reg_write, m2_alu_src_a;
  logic [1:0] m2_alu_src_b, m2_alu_op, m2_pc_src;
  logic m2_illegal;
  logic [3:0] m2_state_dbg;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } cw_t;

  cw_t   exp_q[$];
  int    st_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail = 0;

  cw_t   mon_e, mon_a;
  int    mon_s;
  string mon_t;

  logic [5:0] legal_ops [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
    .mem_req (mem_req), .mem_we (mem_we), .iord (iord), .ir_write (ir_write), .pc_en (pc_en),
    .reg_dst (reg_dst), .mem_to_reg (mem_to_reg), .reg_write (reg_write),
    .alu_src_a (alu_src_a), .alu_src_b (alu_src_b), .alu_op (alu_op), .pc_src (pc_src),
    .illegal (illegal), .state_dbg (state_dbg)
  );

  multicycle_control #(.SUPPORT_BNE (1'b0), .SUPPORT_J (1'b0)) u_dut_min (
    .clk (clk), .rst_n (rst2_n), .opcode (opcode), .zero (zero), .mem_ready (mem_ready),
    .mem_req (m2_mem_req), .mem_we (m2_mem_we), .iord (m2_iord), .ir_write (m2_ir_write),
    .pc_en (m2_pc_en), .reg_dst (m2_reg_dst), .mem_to_reg (m2_mem_to_reg),
    .reg_write (m2_reg_write), .alu_src_a (m2_alu_src_a), .alu_src_b (m2_alu_src_b),
    .alu_op (m2_alu_op), .pc_src (m2_pc_src), .illegal (m2_illegal), .state_dbg (m2_state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic int wait_len();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction

  // Monitor: one expected control word per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_s = st_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {mem_req, mem_we, iord, ir_write, pc_en, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal};
      chk({mon_t, " ctl"}, 32'(mon_a), 32'(mon_e));
      if (mon_s >= 0) chk({mon_t, " state"}, 32'(state_dbg), mon_s[31:0]);
    end
  end

  // Advance one cycle, drive inputs, and queue what the control word must be this cycle.
  task automatic step(input logic mr, input logic z, input cw_t e, input int st,
                      input string tag);
    @(posedge clk);
    #1;
    opcode    = cur_op;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    st_q.push_back(st);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    step(rb(), rb(), '0, 0, "reset");
    rst_n = 1'b0;
    step(rb(), rb(), '0, 0, "reset_hold");
    step(rb(), rb(), '0, 0, "reset_release");
    rst_n = 1'b1;
  endtask

  task automatic run_fetch();
    cw_t c;
    int  w;
    w = wait_len();
    for (int k = 0; k <= w; k++) begin
      c = '0;
      c.mem_req   = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write  = (k == w);
      c.pc_en     = (k == w);
      step(k == w, rb(), c, 1, "fetch");
    end
  endtask

  task automatic run_instr(input logic [5:0] op);
    cw_t   c;
    int    w;
    logic  z;
    string t;
    cur_op = op;
    run_fetch();
    c = '0;
    c.alu_src_b = 2'b11;
    step(rb(), rb(), c, -1, "decode");
    case (op)
      OP_LW, OP_SW: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        step(rb(), rb(), c, -1, "memadr");
        t = (op == OP_SW) ? "memwr" : "memrd";
        w = wait_len();
        for (int k = 0; k <= w; k++) begin
          c = '0;
          c.mem_req = 1'b1;
          c.iord    = 1'b1;
          c.mem_we  = (op == OP_SW);
          step(k == w, rb(), c, -1, t);
        end
        if (op == OP_LW) begin
          c = '0;
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          step(rb(), rb(), c, -1, "memwb");
        end
      end
      OP_RTYPE: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        step(rb(), rb(), c, -1, "rtype_ex");
        c = '0;
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        step(rb(), rb(), c, -1, "rtype_wb");
      end
      OP_BEQ, OP_BNE: begin
        z = rb();
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.pc_en     = (op == OP_BNE) ? ~z : z;
        step(rb(), z, c, -1, (op == OP_BNE) ? "bne" : "beq");
      end
      OP_ADDI: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        step(rb(), rb(), c, -1, "addi_ex");
        c = '0;
        c.reg_write = 1'b1;
        step(rb(), rb(), c, -1, "addi_wb");
      end
      OP_J: begin
        c = '0;
        c.pc_src = 2'b10;
        c.pc_en  = 1'b1;
        step(rb(), rb(), c, -1, "jump");
      end
      default: begin
        c = '0;
        c.illegal = 1'b1;
        for (int k = 0; k < 4; k++) step(rb(), rb(), c, 15, "error");
      end
    endcase
  endtask

  // Reduced-configuration instance: disabled opcode must trap and stop requesting memory.
  task automatic min_cfg_trap(input logic [5:0] op, input string nm);
    @(posedge clk);
    #1;
    rst2_n = 1'b0;
    #2;
    chk({nm, " reset_req"}, 32'(m2_mem_req), 32'd0);
    chk({nm, " reset_state"}, 32'(m2_state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    opcode = op;
    mem_ready = 1'b1;
    chk({nm, " fetch_req"}, 32'(m2_mem_req), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      mem_ready = rb();
      #1;
      chk({nm, " illegal"}, 32'(m2_illegal), 32'd1);
      chk({nm, " no_req"}, 32'(m2_mem_req), 32'd0);
      chk({nm, " state"}, 32'(m2_state_dbg), 32'd15);
    end
  endtask

  initial begin
    cw_t        c;
    logic [5:0] op;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 20; i++) run_instr(legal_ops[$urandom_range(0, 6)]);
      if (r == 0) begin
        op = 6'h3F;
      end else begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end
      run_instr(op);
    end

    // Reset in the middle of a stalled load read must drop mem_req at once.
    do_reset();
    cur_op = OP_LW;
    run_fetch();
    c = '0;
    c.alu_src_b = 2'b11;
    step(1'b0, 1'b0, c, -1, "decode");
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'b10;
    step(1'b1, 1'b0, c, -1, "memadr");
    c = '0;
    c.mem_req = 1'b1;
    c.iord    = 1'b1;
    step(1'b0, 1'b0, c, -1, "memrd_stall");
    step(1'b0, 1'b0, '0, 0, "async_drop");
    #2;
    rst_n = 1'b0;
    step(1'b1, 1'b0, '0, 0, "reset_hold");
    step(1'b1, 1'b0, '0, 0, "reset_release");
    rst_n = 1'b1;
    run_instr(OP_LW);
    run_instr(OP_SW);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);

    min_cfg_trap(OP_BNE, "min_bne");
    min_cfg_trap(OP_J, "min_j");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
